// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data/control
// widths, ALU op codes, FSM state encoding and the operand bundle that
// the arbiter latches for the granted requester.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  // ALU op codes; every other code yields a zero result
  localparam logic [CTRL_W-1:0] OP_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] OP_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] OP_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] OP_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Operands captured from the winning requester
  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [CTRL_W-1:0] ctrl;
  } alu_op_t;

  function automatic logic is_zero(input logic [DATA_W-1:0] value);
    return (value == '0);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: AND, OR, ADD, SUB (modulo 2^DATA_W) and signed SLT.
// Ports:
//   src1_i, src2_i  operands
//   ctrl_i          op code
//   result_c_o      combinational result (0 for unsupported codes)
//   zero_c_o        combinational flag, 1 when result_c_o is zero
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] result_c_o,
  output logic              zero_c_o
);

  // Op decode; carries and overflow are deliberately dropped
  always_comb begin
    result_c_o = '0;
    case (ctrl_i)
      OP_AND:  result_c_o = src1_i & src2_i;
      OP_OR:   result_c_o = src1_i | src2_i;
      OP_ADD:  result_c_o = src1_i + src2_i;
      OP_SUB:  result_c_o = src1_i - src2_i;
      OP_SLT:  result_c_o = DATA_W'($signed(src1_i) < $signed(src2_i));
      default: result_c_o = '0;
    endcase
  end

  assign zero_c_o = is_zero(result_c_o);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// A request is captured in IDLE (or in RESP on the ack edge), executed in
// the following EXEC cycle, and its registered result is offered in RESP
// until acknowledged.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   req0_i/req1_i              requests (held until the matching grant)
//   src1_N_i, src2_N_i, ctrlN_i operands / op code of requester N
//   gnt0_o/gnt1_o              one-cycle grant pulse during EXEC
//   rsp_valid_o, rsp_ack_i     response handshake
//   rsp_id_o, result_o, zero_o response payload, stable while valid
//   busy_o                     high whenever the arbiter is not idle
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [DATA_W-1:0] src1_0_i,
  input  logic [DATA_W-1:0] src2_0_i,
  input  logic [DATA_W-1:0] src1_1_i,
  input  logic [DATA_W-1:0] src2_1_i,
  input  logic [CTRL_W-1:0] ctrl0_i,
  input  logic [CTRL_W-1:0] ctrl1_i,
  input  logic              rsp_ack_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rsp_valid_o,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic              last_q, last_d;      // 1: requester 1 was granted last
  alu_op_t           op_q, op_d;
  logic              owner_q, owner_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              busy_q, busy_d;

  logic              any_req_c;
  logic              win_c;               // 1: requester 1 wins this capture
  logic              capture_c;
  alu_op_t           req_op0_c, req_op1_c;
  logic [DATA_W-1:0] alu_result_c;
  logic              alu_zero_c;

  assign any_req_c = req0_i | req1_i;
  // On a tie the requester that was not granted last wins
  assign win_c     = (req0_i & req1_i) ? ~last_q : req1_i;
  assign req_op0_c = {src1_0_i, src2_0_i, ctrl0_i};
  assign req_op1_c = {src1_1_i, src2_1_i, ctrl1_i};

  // Shared ALU fed only from the operand latches
  alu_arbiter_alu u_alu (
    .src1_i     (op_q.src1),
    .src2_i     (op_q.src2),
    .ctrl_i     (op_q.ctrl),
    .result_c_o (alu_result_c),
    .zero_c_o   (alu_zero_c)
  );

  // Next-state, capture and response logic
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_d        = op_q;
    owner_d     = owner_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    result_d    = result_q;
    zero_d      = zero_q;
    capture_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        capture_c = any_req_c;
      end
      ST_EXEC: begin
        result_d    = alu_result_c;
        zero_d      = alu_zero_c;
        rsp_id_d    = owner_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Response payload holds until the ack edge; a waiting request
        // is captured on that same edge
        if (rsp_ack_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
          capture_c   = any_req_c;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (capture_c) begin
      op_d    = win_c ? req_op1_c : req_op0_c;
      owner_d = win_c;
      last_d  = win_c;
      gnt0_d  = ~win_c;
      gnt1_d  = win_c;
      state_d = ST_EXEC;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      op_q        <= '0;
      owner_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      op_q        <= op_d;
      owner_q     <= owner_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic, with a grant-time scoreboard and an independent response monitor.
module tb_alu_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_i, req1_i;
  logic [31:0] src1_0_i, src2_0_i, src1_1_i, src2_1_i;
  logic [3:0]  ctrl0_i, ctrl1_i;
  logic        rsp_ack_i = 1'b0;
  logic        gnt0_o, gnt1_o, rsp_valid_o, rsp_id_o, zero_o, busy_o;
  logic [31:0] result_o;

  always #5 clk_i = ~clk_i;

  alu_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req0_i      (req0_i),
    .req1_i      (req1_i),
    .src1_0_i    (src1_0_i),
    .src2_0_i    (src2_0_i),
    .src1_1_i    (src1_1_i),
    .src2_1_i    (src2_1_i),
    .ctrl0_i     (ctrl0_i),
    .ctrl1_i     (ctrl1_i),
    .rsp_ack_i   (rsp_ack_i),
    .gnt0_o      (gnt0_o),
    .gnt1_o      (gnt1_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_id_o    (rsp_id_o),
    .result_o    (result_o),
    .zero_o      (zero_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t        exp_q[$];
  int          glog[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rep0 = 0, rep1 = 0;
  int          wait0 = 0, wait1 = 0;
  int          ack_mode = 2;      // 0 random, 1 hold low, 2 always high
  bit          rand_mode = 1'b0;
  logic        last_m = 1'b1;     // reference round-robin pointer
  logic [3:0]  codes [8] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h3, 4'hF, 4'h2};

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h6:    return a - b;
      4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 15));
      2:       return 32'hFFFF_FFFF;
      default: return 32'h8000_0000;
    endcase
  endfunction

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    if (id == 0) begin
      req0_i = 1'b1; src1_0_i = a; src2_0_i = b; ctrl0_i = c;
    end else begin
      req1_i = 1'b1; src1_1_i = a; src2_1_i = b; ctrl1_i = c;
    end
  endtask

  task automatic rand_req(input int id);
    set_req(id, rand_val(), rand_val(), codes[$urandom_range(0, 7)]);
  endtask

  // One clock: check grants against the round-robin rule, record the
  // expected response, then update requester behaviour.
  task automatic step();
    logic g0, g1, w;
    exp_t e;
    @(negedge clk_i);
    if (rst_i) last_m = 1'b1;
    g0 = gnt0_o;
    g1 = gnt1_o;
    chk("busy", 64'(busy_o), 64'(g0 | g1 | rsp_valid_o));
    if (g0 || g1) begin
      chk("gnt_exclusive", 64'(g0 & g1), 64'(0));
      chk("gnt_has_req", 64'(req0_i | req1_i), 64'(1));
      w = (req0_i && req1_i) ? ~last_m : req1_i;
      chk("gnt_winner", 64'(g1), 64'(w));
      last_m = w;
      glog.push_back(int'(w));
      e.id  = w;
      e.res = w ? ref_alu(src1_1_i, src2_1_i, ctrl1_i) : ref_alu(src1_0_i, src2_0_i, ctrl0_i);
      e.zero = (e.res == 32'd0);
      exp_q.push_back(e);
      if (w == 1'b0) begin
        wait0 = 0;
        if (rep0 > 0) rep0--;
        else if (rand_mode && $urandom_range(0, 1) == 1) rand_req(0);
        else req0_i = 1'b0;
      end else begin
        wait1 = 0;
        if (rep1 > 0) rep1--;
        else if (rand_mode && $urandom_range(0, 1) == 1) rand_req(1);
        else req1_i = 1'b0;
      end
    end
    if (req0_i) wait0++; else wait0 = 0;
    if (req1_i) wait1++; else wait1 = 0;
    if (wait0 > 40) begin fail_now("req0_starved"); req0_i = 1'b0; wait0 = 0; end
    if (wait1 > 40) begin fail_now("req1_starved"); req1_i = 1'b0; wait1 = 0; end
    if (rand_mode) begin
      if (!req0_i && $urandom_range(0, 2) == 0) rand_req(0);
      if (!req1_i && $urandom_range(0, 2) == 0) rand_req(1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((req0_i || req1_i || exp_q.size() != 0 || rsp_valid_o) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) fail_now("drain_timeout");
  endtask

  task automatic single_op(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
    set_req(id, a, b, c);
    step();
    chk("lat_gnt", 64'((id == 0) ? gnt0_o : gnt1_o), 64'(1));
    step();
    chk("lat_rsp", 64'(rsp_valid_o), 64'(1));
    wait_idle();
  endtask

  // Response monitor: pops on the first cycle of each response, checks the
  // payload stays put until acked, and drives the ack.
  initial begin : monitor
    logic        fresh;
    logic        ack;
    logic [33:0] held;
    exp_t        e;
    fresh = 1'b1;
    held  = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_i) begin
        rsp_ack_i = 1'b0;
        fresh     = 1'b1;
      end else begin
        if (rsp_valid_o) begin
          if (fresh) begin
            if (exp_q.size() == 0) begin
              fail_now("rsp_unexpected");
            end else begin
              e = exp_q.pop_front();
              chk("rsp_result", 64'(result_o), 64'(e.res));
              chk("rsp_zero", 64'(zero_o), 64'(e.zero));
              chk("rsp_id", 64'(rsp_id_o), 64'(e.id));
            end
            held  = {rsp_id_o, zero_o, result_o};
            fresh = 1'b0;
          end else begin
            chk("rsp_stable", 64'({rsp_id_o, zero_o, result_o}), 64'(held));
          end
        end
        case (ack_mode)
          1:       ack = 1'b0;
          2:       ack = 1'b1;
          default: ack = ($urandom_range(0, 2) != 0);
        endcase
        rsp_ack_i = ack;
        if (rsp_valid_o && ack) fresh = 1'b1;
      end
    end
  end

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    exp_t e;
    rst_i = 1'b1;
    req0_i = 1'b0; req1_i = 1'b0;
    src1_0_i = '0; src2_0_i = '0; src1_1_i = '0; src2_1_i = '0;
    ctrl0_i = '0; ctrl1_i = '0;

    // Reset beats pending requests; both stay pending for the tie test
    set_req(0, 32'd1, 32'd1, 4'h2);
    set_req(1, 32'd2, 32'd2, 4'h2);
    rep0 = 1;
    repeat (3) begin
      step();
      chk("rst_gnt0", 64'(gnt0_o), 64'(0));
      chk("rst_gnt1", 64'(gnt1_o), 64'(0));
      chk("rst_valid", 64'(rsp_valid_o), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(0));
    end
    chk("rst_payload", 64'({rsp_id_o, zero_o, result_o}), 64'(0));
    glog.delete();
    rst_i = 1'b0;
    wait_idle();
    chk("tie_count", 64'(glog.size()), 64'(3));
    if (glog.size() >= 3) begin
      chk("tie_first", 64'(glog[0]), 64'(0));
      chk("tie_second", 64'(glog[1]), 64'(1));
      chk("tie_third", 64'(glog[2]), 64'(0));
    end

    // Single ops, arithmetic boundaries and unsupported code
    single_op(0, 32'd5, 32'd3, 4'b0010);
    single_op(1, 32'd7, 32'd7, 4'b0110);
    single_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0111);
    single_op(1, 32'd1, 32'hFFFF_FFFF, 4'b0111);
    single_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0010);
    single_op(1, 32'h12, 32'h34, 4'b0011);
    single_op(0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0000);
    single_op(1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b0001);

    // Backpressure: response held, req1 waits until the ack edge
    ack_mode = 1;
    set_req(0, 32'd10, 32'd20, 4'b0001);
    repeat (2) step();
    chk("bp_valid_start", 64'(rsp_valid_o), 64'(1));
    set_req(1, 32'd100, 32'd1, 4'b0110);
    repeat (5) begin
      step();
      chk("bp_no_gnt1", 64'(gnt1_o), 64'(0));
      chk("bp_valid_held", 64'(rsp_valid_o), 64'(1));
    end
    ack_mode = 2;
    step();
    chk("bp_gnt1", 64'(gnt1_o), 64'(1));
    wait_idle();

    // Reset during EXEC drops the in-flight op
    set_req(0, 32'd9, 32'd4, 4'b0110);
    step();
    chk("rx_gnt0", 64'(gnt0_o), 64'(1));
    rst_i = 1'b1;
    if (exp_q.size() > 0) e = exp_q.pop_back();
    step();
    chk("rx_outputs", 64'({gnt0_o, gnt1_o, rsp_valid_o, rsp_id_o, zero_o, busy_o}), 64'(0));
    chk("rx_result", 64'(result_o), 64'(0));
    rst_i = 1'b0;
    repeat (3) begin
      step();
      chk("rx_no_rsp", 64'(rsp_valid_o), 64'(0));
    end
    single_op(0, 32'd40, 32'd2, 4'b0010);

    // Randomized traffic with random acks
    ack_mode  = 0;
    rand_mode = 1'b1;
    repeat (400) step();
    rand_mode = 1'b0;
    ack_mode  = 2;
    wait_idle();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_i  input  1  reset, synchronous, active-high.
REQ-003 req0_i / req1_i  input  1 each  operation request from requester 0 / 1.
REQ-004 src1_0_i, src2_0_i / src1_1_i, src2_1_i  input  32 each  operands of requester 0 / 1.
REQ-005 ctrl0_i / ctrl1_i  input  4 each  ALU op code of requester 0 / 1.
REQ-006 gnt0_o / gnt1_o  output  1 each  one-cycle grant pulse; operands of that requester captured.
REQ-007 rsp_valid_o  output  1  response valid; result_o, zero_o, rsp_id_o stable while high.
REQ-008 rsp_id_o  output  1  index of requester owning the response.
REQ-009 result_o  output  32  registered ALU result.
REQ-010 zero_o  output  1  registered, 1 when result_o == 0.
REQ-011 rsp_ack_i  input  1  consumer accepts response; sampled only while rsp_valid_o = 1.
REQ-012 busy_o  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, EXEC, RESP; registered state.
REQ-014 IDLE: if any req at edge -> capture winner's src1/src2/ctrl into operand latches, set owner id, state EXEC; else stay IDLE.
REQ-015 Arbitration round-robin: on simultaneous req0/req1, grant requester != last-granted; single request always wins.
REQ-016 Last-granted pointer updates only on a capture edge.
REQ-017 gntN_o high for exactly the one cycle following capture (the EXEC cycle), never both at once.
REQ-018 Requester SHALL hold req and operands until it sees gnt; req still high in the cycle after gnt is a new request.
REQ-019 EXEC: ALU driven combinationally from latched operands; at edge register result_o, zero_o, rsp_id_o, set rsp_valid_o = 1, state RESP.
REQ-020 Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0); any other code -> result 0, zero 1.
REQ-021 ADD/SUB wrap modulo 2^32; no carry/overflow output.
REQ-022 Latency: request sampled at edge N -> gnt during cycle N+1 -> rsp_valid_o high from edge N+2.
REQ-023 RESP: hold all response outputs unchanged until rsp_ack_i = 1 at an edge.
REQ-024 RESP with ack and no req -> rsp_valid_o = 0, state IDLE.
REQ-025 RESP with ack and req present -> rsp_valid_o = 0, capture per REQ-014/015 in same edge, state EXEC (one op per 2 cycles sustained).
REQ-026 Requests arriving during EXEC, or during RESP without ack, are not captured and not lost; served once arbiter returns to a capture point.
REQ-027 rsp_ack_i while rsp_valid_o = 0 has no effect.

Reset
REQ-028 rst_i high at an edge: state IDLE, gnt0_o = gnt1_o = 0, rsp_valid_o = 0, rsp_id_o = 0, result_o = 0, zero_o = 0, busy_o = 0, last-granted = 1 (requester 0 wins first tie).
REQ-029 Reset mid-operation (EXEC or RESP) discards the in-flight op; no response is produced for it.
REQ-030 Reset takes priority over all requests and acks in the same cycle.

Structure
REQ-031 Shared package holds: 4-bit op-code constants (AND/OR/ADD/SUB/SLT), data width 32, FSM state encoding.
REQ-032 Exactly one sub-module: the team's existing ALU module, instantiated once, fed from operand latches.
REQ-033 No other arithmetic duplicated in alu_arbiter.

Verification
REQ-034 Single op: req0, src1=5, src2=3, ctrl=0010 -> gnt0 at N+1, rsp_valid N+2, result 8, zero 0, id 0.
REQ-035 Tie: req0 and req1 both held after reset -> first gnt0, after ack gnt1, then gnt0; never both grants high.
REQ-036 SUB/SLT boundaries: 7-7 ctrl 0110 -> result 0, zero 1; src1=0xFFFFFFFF, src2=1, ctrl 0111 -> result 1; 0+0xFFFFFFFF... 0xFFFFFFFF+1 ctrl 0010 -> result 0, zero 1.
REQ-037 Backpressure: hold rsp_ack_i=0 for 5 cycles with req1 pending -> outputs stable, no gnt1; ack -> gnt1 next cycle.
REQ-038 Reset in EXEC: rst_i pulsed at EXEC edge -> rsp_valid stays 0, all outputs 0, next req0 serviced normally.
REQ-039 Unsupported ctrl 0011 with src 0x12/0x34 -> result 0, zero 1.
